pdu_imem_arbiter: RTL and testbench

Shares the single synchronous read port of the PDU instruction memory between two requesters: the CPU fetch path and the PDU debug/inspection path. It accepts valid/ready read requests, arbitrates, drives the IMEM address, captures the one-cycle-latency read data, and returns it on a per-requester valid/ready response channel. It sits directly between the IMEM and its two consumers inside the PDU, and has at most one read outstanding at any time.

---
 rtl/pdu_imem_arbiter.sv | 150 +++++++++++++++
 tb/tb_pdu_imem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdu_imem_arbiter.sv
// pdu_imem_arbiter
// Shares the single synchronous read port of the PDU instruction memory
// between the CPU fetch path and the PDU debug/inspection path. Requests use
// valid/ready handshakes. The read data is captured one cycle after the
// address is presented, and it is returned on the owning requester's
// response channel. Only one read is outstanding at any time.
//
// Ports
//   sys_clk, sys_rst          clock and synchronous active-high reset
//   cpu_req_valid/addr/ready  CPU read request channel
//   cpu_resp_valid/data/ready CPU response channel
//   pdu_req_valid/addr/ready  PDU debug read request channel
//   pdu_resp_valid/data/ready PDU response channel
//   imem_addr, imem_data      IMEM read port (data valid one cycle later)
//   arb_busy                  high whenever a read is outstanding
//
// Configuration
//   PDU_IMEM_ARB_RR_EN  when defined, conflicts are resolved round-robin.
//                       The first conflict after reset goes to the CPU.
//                       When undefined, the PDU always wins a conflict.
module pdu_imem_arbiter #(
  parameter int DEPTH = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cpu_req_valid,
  input  logic [DEPTH-1:0] cpu_req_addr,
  output logic             cpu_req_ready,
  output logic             cpu_resp_valid,
  output logic [31:0]      cpu_resp_data,
  input  logic             cpu_resp_ready,
  input  logic             pdu_req_valid,
  input  logic [DEPTH-1:0] pdu_req_addr,
  output logic             pdu_req_ready,
  output logic             pdu_resp_valid,
  output logic [31:0]      pdu_resp_data,
  input  logic             pdu_resp_ready,
  output logic [DEPTH-1:0] imem_addr,
  input  logic [31:0]      imem_data,
  output logic             arb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;   // 0: CPU, 1: PDU
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [31:0]      data_q, data_d;

  logic             owner_resp_ready;
  logic             issue;
  logic             win_pdu;
  logic [DEPTH-1:0] win_addr;

`ifdef PDU_IMEM_ARB_RR_EN
  logic             last_q;             // last winner: 0 CPU, 1 PDU

  // Round-robin pointer. It moves only when a read is actually issued.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_q <= 1'b1;                   // "PDU last" so the CPU wins first
    end else if (issue) begin
      last_q <= win_pdu;
    end
  end
`endif

  // Arbitration and issue decision
  always_comb begin
    owner_resp_ready = owner_q ? pdu_resp_ready : cpu_resp_ready;
    if (cpu_req_valid && pdu_req_valid) begin
`ifdef PDU_IMEM_ARB_RR_EN
      win_pdu = ~last_q;
`else
      win_pdu = 1'b1;
`endif
    end else begin
      win_pdu = pdu_req_valid;
    end
    win_addr = win_pdu ? pdu_req_addr : cpu_req_addr;
    // Gating with sys_rst prevents a handshake that the reset would lose.
    // Issue is allowed in IDLE, or in RESP in the same cycle that the
    // owner takes its response (back-to-back).
    issue = !sys_rst && (cpu_req_valid || pdu_req_valid) &&
            ((state_q == ST_IDLE) ||
             ((state_q == ST_RESP) && owner_resp_ready));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_READ: begin
        data_d  = imem_data;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      owner_d = win_pdu;
      addr_d  = win_addr;
      state_d = ST_READ;
    end
  end

  // State registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Output decode
  always_comb begin
    cpu_req_ready  = issue && !win_pdu;
    pdu_req_ready  = issue && win_pdu;
    // The address goes straight through on issue so that IMEM samples it
    // this cycle. Otherwise the address of the last accepted read is held.
    imem_addr      = issue ? win_addr : addr_q;
    cpu_resp_valid = (state_q == ST_RESP) && !owner_q;
    pdu_resp_valid = (state_q == ST_RESP) && owner_q;
    cpu_resp_data  = data_q;
    pdu_resp_data  = data_q;
    arb_busy       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_pdu_imem_arbiter.sv
module tb_pdu_imem_arbiter;
  localparam int DEPTH = 12;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             cpu_req_valid = 1'b0;
  logic [DEPTH-1:0] cpu_req_addr = '0;
  logic             cpu_req_ready;
  logic             cpu_resp_valid;
  logic [31:0]      cpu_resp_data;
  logic             cpu_resp_ready = 1'b0;
  logic             pdu_req_valid = 1'b0;
  logic [DEPTH-1:0] pdu_req_addr = '0;
  logic             pdu_req_ready;
  logic             pdu_resp_valid;
  logic [31:0]      pdu_resp_data;
  logic             pdu_resp_ready = 1'b0;
  logic [DEPTH-1:0] imem_addr;
  logic [31:0]      imem_data = 32'd0;
  logic             arb_busy;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Scoreboard entries are {owner, data}, with owner 0 = CPU and 1 = PDU.
  logic [32:0] sb[$];

  // The reference model tracks one outstanding transaction.
  bit               m_busy      = 1'b0;
  bit               m_avail     = 1'b0;  // response is presentable
  bit               m_owner     = 1'b0;
  bit               m_rr_last   = 1'b1;
  logic [DEPTH-1:0] m_last_addr = '0;
  bit               m_cpu_gnt   = 1'b0;
  bit               m_pdu_gnt   = 1'b0;

  pdu_imem_arbiter #(.DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_data(cpu_resp_data), .cpu_resp_ready(cpu_resp_ready),
    .pdu_req_valid(pdu_req_valid), .pdu_req_addr(pdu_req_addr),
    .pdu_req_ready(pdu_req_ready), .pdu_resp_valid(pdu_resp_valid),
    .pdu_resp_data(pdu_resp_data), .pdu_resp_ready(pdu_resp_ready),
    .imem_addr(imem_addr), .imem_data(imem_data), .arb_busy(arb_busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] mem_word(input logic [DEPTH-1:0] a);
    return 32'h1000_0000 + {20'd0, a};
  endfunction

  // IMEM: synchronous read with one cycle of latency.
  always @(posedge sys_clk) imem_data <= mem_word(imem_addr);

  function automatic bit pick_pdu(input bit cv, input bit pv, input bit last);
    if (cv && pv) begin
`ifdef PDU_IMEM_ARB_RR_EN
      return !last;
`else
      return 1'b1;
`endif
    end
    return pv;
  endfunction

  function automatic bit model_can_issue();
    bit own_rdy;
    own_rdy = m_owner ? pdu_resp_ready : cpu_resp_ready;
    return !sys_rst && (!m_busy || (m_avail && own_rdy));
  endfunction

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b", n, act, exp);
  endtask

  task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // Model update at each active edge. It uses the inputs that are held
  // through the edge.
  initial forever begin
    bit can, any, win;
    logic [DEPTH-1:0] a;
    @(posedge sys_clk);
    cyc++;
    if (sys_rst) begin
      m_busy = 1'b0; m_avail = 1'b0; m_owner = 1'b0; m_rr_last = 1'b1;
      m_last_addr = '0; m_cpu_gnt = 1'b0; m_pdu_gnt = 1'b0;
      sb.delete();
    end else begin
      can = model_can_issue();
      any = cpu_req_valid || pdu_req_valid;
      win = pick_pdu(cpu_req_valid, pdu_req_valid, m_rr_last);
      m_cpu_gnt = can && any && !win;
      m_pdu_gnt = can && any && win;
      if (can && any) begin
        a = win ? pdu_req_addr : cpu_req_addr;
        m_busy = 1'b1; m_avail = 1'b0; m_owner = win;
        m_last_addr = a; m_rr_last = win;
        sb.push_back({win, mem_word(a)});
      end else if (m_busy && m_avail &&
                   (m_owner ? pdu_resp_ready : cpu_resp_ready)) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_avail = 1'b1;
      end
    end
  end

  // Mid-cycle comparison of handshake, address and status outputs.
  initial forever begin
    bit can, any, win;
    @(negedge sys_clk);
    can = model_can_issue();
    any = cpu_req_valid || pdu_req_valid;
    win = pick_pdu(cpu_req_valid, pdu_req_valid, m_rr_last);
    chk1("cpu_req_ready", cpu_req_ready, can && any && !win);
    chk1("pdu_req_ready", pdu_req_ready, can && any && win);
    chk32("imem_addr", {20'd0, imem_addr},
          {20'd0, (can && any) ? (win ? pdu_req_addr : cpu_req_addr) : m_last_addr});
    chk1("cpu_resp_valid", cpu_resp_valid, m_busy && m_avail && !m_owner);
    chk1("pdu_resp_valid", pdu_resp_valid, m_busy && m_avail && m_owner);
    chk1("arb_busy", arb_busy, m_busy);
  end

  // Response monitor. It compares each presented response with the
  // scoreboard head and pops the head on handshake.
  initial forever begin
    @(negedge sys_clk);
    if (cpu_resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL cpu_resp_unexpected: got data %h expected no response", cpu_resp_data);
      end else begin
        chk1("cpu_resp_owner", sb[0][32], 1'b0);
        chk32("cpu_resp_data", cpu_resp_data, sb[0][31:0]);
        if (cpu_resp_ready) void'(sb.pop_front());
      end
    end
    if (pdu_resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL pdu_resp_unexpected: got data %h expected no response", pdu_resp_data);
      end else begin
        chk1("pdu_resp_owner", sb[0][32], 1'b1);
        chk32("pdu_resp_data", pdu_resp_data, sb[0][31:0]);
        if (pdu_resp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  // The request is left asserted on return so that a caller can stream.
  task automatic cpu_req(input logic [DEPTH-1:0] a);
    int n;
    n = 0;
    cpu_req_valid = 1'b1; cpu_req_addr = a;
    do begin cycle(); n++; end while (!m_cpu_gnt && n < 40);
    if (!m_cpu_gnt) begin
      checks++;
      $display("FAIL cpu_req_timeout: got no grant expected grant for addr %h", a);
    end
  endtask

  task automatic pdu_req(input logic [DEPTH-1:0] a);
    int n;
    n = 0;
    pdu_req_valid = 1'b1; pdu_req_addr = a;
    do begin cycle(); n++; end while (!m_pdu_gnt && n < 40);
    if (!m_pdu_gnt) begin
      checks++;
      $display("FAIL pdu_req_timeout: got no grant expected grant for addr %h", a);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_busy && n < 40) begin cycle(); n++; end
    if (m_busy) begin
      checks++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
  endtask

  initial begin
    int t_prev;
    bit seq[$];
    repeat (3) cycle();
    sys_rst = 1'b0;
    cycle();
    chk32("rst_imem_addr", {20'd0, imem_addr}, 32'd0);
    chk32("rst_cpu_resp_data", cpu_resp_data, 32'd0);
    chk1("rst_arb_busy", arb_busy, 1'b0);
    chk1("rst_cpu_resp_valid", cpu_resp_valid, 1'b0);

    // A single CPU read with a latency of 2 cycles.
    cpu_resp_ready = 1'b1; pdu_resp_ready = 1'b1;
    cpu_req(12'h005);
    cpu_req_valid = 1'b0;
    chk1("lat_n1_cpu_resp_valid", cpu_resp_valid, 1'b0);
    cycle();
    chk1("lat_n2_cpu_resp_valid", cpu_resp_valid, 1'b1);
    chk32("lat_n2_cpu_resp_data", cpu_resp_data, 32'h1000_0005);
    chk1("lat_n2_pdu_resp_valid", pdu_resp_valid, 1'b0);
    drain();

    // A CPU stream of 0x010..0x013 at one read every 2 cycles.
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_req(12'h010 + 12'(i));
      if (i > 0) chk32("stream_interval", 32'(cyc - t_prev), 32'd2);
      t_prev = cyc;
    end
    cpu_req_valid = 1'b0;
    drain();

    // Both requesters request every cycle, starting fresh from reset.
    sys_rst = 1'b1; cycle(); sys_rst = 1'b0;
    cpu_req_valid = 1'b1; cpu_req_addr = 12'h020;
    pdu_req_valid = 1'b1; pdu_req_addr = 12'h030;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (cpu_req_ready) seq.push_back(1'b0);
      else if (pdu_req_ready) seq.push_back(1'b1);
      cycle();
    end
    chk1("conflict_grant_count", seq.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < seq.size(); i++) begin
`ifdef PDU_IMEM_ARB_RR_EN
      chk1("conflict_rr_winner", seq[i], (i % 2) == 1);
`else
      chk1("conflict_fixed_winner", seq[i], 1'b1);
`endif
    end
    cpu_req_valid = 1'b0; pdu_req_valid = 1'b0;
    drain();

    // A PDU response is stalled and the CPU waits for the handshake cycle.
    pdu_req(12'h0FF);
    pdu_req_valid = 1'b0; pdu_resp_ready = 1'b0;
    cpu_req_valid = 1'b1; cpu_req_addr = 12'h001;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk1("stall_pdu_resp_valid", pdu_resp_valid, 1'b1);
      chk32("stall_pdu_resp_data", pdu_resp_data, 32'h1000_00FF);
      chk1("stall_cpu_req_ready", cpu_req_ready, 1'b0);
    end
    pdu_resp_ready = 1'b1;
    #1;
    chk1("b2b_cpu_req_ready", cpu_req_ready, 1'b1);
    cycle();
    cpu_req_valid = 1'b0;
    drain();

    // Reset during READ discards the read.
    cpu_req(12'h040);
    cpu_req_valid = 1'b0;
    sys_rst = 1'b1; cycle(); sys_rst = 1'b0;
    chk1("rstrd_arb_busy", arb_busy, 1'b0);
    chk1("rstrd_cpu_resp_valid", cpu_resp_valid, 1'b0);
    chk32("rstrd_imem_addr", {20'd0, imem_addr}, 32'd0);
    chk32("rstrd_cpu_resp_data", cpu_resp_data, 32'd0);
    repeat (4) cycle();
    cpu_req(12'h041);
    cpu_req_valid = 1'b0;
    drain();

    // Top address
    pdu_req(12'hFFF);
    pdu_req_valid = 1'b0;
    cycle();
    chk32("top_addr_data", pdu_resp_data, 32'h1000_0FFF);
    drain();

    // Randomized traffic with back-pressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (!cpu_req_valid || m_cpu_gnt) begin
        cpu_req_valid = ($urandom_range(0, 2) != 0);
        cpu_req_addr  = 12'($urandom);
      end
      if (!pdu_req_valid || m_pdu_gnt) begin
        pdu_req_valid = ($urandom_range(0, 2) != 0);
        pdu_req_addr  = 12'($urandom);
      end
      cpu_resp_ready = ($urandom_range(0, 3) != 0);
      pdu_resp_ready = ($urandom_range(0, 3) != 0);
      sys_rst        = ($urandom_range(0, 99) == 0);
      cycle();
    end
    sys_rst = 1'b0;
    cpu_req_valid = 1'b0; pdu_req_valid = 1'b0;
    cpu_resp_ready = 1'b1; pdu_resp_ready = 1'b1;
    drain();
    cycle();
    chk32("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
